// File: rtl/div_32.sv
// +--------------------------------------------------------------------------+
// | Module   : div_32 (with helper add_sub_32)                               |
// | Purpose  : Sequential restoring divider, one quotient bit per cycle,     |
// |            start/done handshake. Optional macro DIV_SIGNED_EN selects    |
// |            two's-complement operands (truncating toward zero).           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module add_sub_32 #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sel,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N-1:0] b_eff;

  // sel=1 subtracts as a + ~b + 1; cout=1 then means "no borrow".
  assign b_eff       = b ^ {N{sel}};
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, sel};
endmodule

module div_32 #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  q_q, q_d;
  logic [N:0]    r_q, r_d;
  logic [N-1:0]  d_q, d_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  quotient_q, quotient_d;
  logic [N-1:0]  remainder_q, remainder_d;
  logic          dbz_q, dbz_d;

  logic [N:0]    r_shift;
  logic [N:0]    diff;
  logic          no_borrow;
  logic [N-1:0]  q_step;
  logic [N:0]    r_step;
  logic [N-1:0]  mag_dividend;
  logic [N-1:0]  mag_divisor;
  logic [N-1:0]  res_quo;
  logic [N-1:0]  res_rem;
  logic          accept;
  logic          unused_r_msb;

  // Partial remainder always stays below the divisor, so its top bit is never shifted in.
  assign unused_r_msb = r_q[N];
  assign r_shift      = {r_q[N-1:0], q_q[N-1]};
  assign accept       = (state_q == IDLE) && start && (divisor != '0);

  add_sub_32 #(.N(N + 1)) u_trial_sub (
    .a    (r_shift),
    .b    ({1'b0, d_q}),
    .sel  (1'b1),
    .sum  (diff),
    .cout (no_borrow)
  );

  assign q_step = {q_q[N-2:0], no_borrow};
  assign r_step = no_borrow ? diff : r_shift;

`ifdef DIV_SIGNED_EN
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;

  assign mag_dividend = dividend[N-1] ? -dividend : dividend;
  assign mag_divisor  = divisor[N-1]  ? -divisor  : divisor;
  assign res_quo      = neg_quo_q ? -q_step : q_step;
  assign res_rem      = neg_rem_q ? -r_step[N-1:0] : r_step[N-1:0];

  always_comb begin
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (accept) begin
      neg_quo_d = dividend[N-1] ^ divisor[N-1];
      neg_rem_d = dividend[N-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`else
  assign mag_dividend = dividend;
  assign mag_divisor  = divisor;
  assign res_quo      = q_step;
  assign res_rem      = r_step[N-1:0];
`endif

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    r_d         = r_q;
    d_d         = d_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = RUN;
            q_d     = mag_dividend;
            d_d     = mag_divisor;
            r_d     = '0;
            count_d = '0;
          end
        end
      end
      RUN: begin
        q_d     = q_step;
        r_d     = r_step;
        count_d = count_q + CW'(1);
        // Last iteration commits the results in the same edge.
        if (count_q == LAST) begin
          state_d     = DONE;
          quotient_d  = res_quo;
          remainder_d = res_rem;
          dbz_d       = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      q_q         <= '0;
      r_q         <= '0;
      d_q         <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      r_q         <= r_d;
      d_q         <= d_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
endmodule

`default_nettype wire

// File: tb/tb_div_32.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_div_32                                                     |
// | Purpose  : Self-checking bench for div_32 against a plain-arithmetic     |
// |            reference; honours DIV_SIGNED_EN.                             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_div_32;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  div_32 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {quotient, remainder} straight from the arithmetic definition.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return {32'hFFFF_FFFF, a};
`ifdef DIV_SIGNED_EN
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    begin
      int sa, sb, qi, ri;
      sa = $signed(a);
      sb = $signed(b);
      qi = sa / sb;
      ri = sa % sb;
      return {qi[31:0], ri[31:0]};
    end
`else
    return {a / b, a % b};
`endif
  endfunction

  // Entered one ns after a clock edge with the divider idle; leaves one ns
  // after the edge where done drops, which is the earliest re-start point.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int          edges;
    exp      = ref_div(a, b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    check("busy_after_e0", {31'b0, busy}, 32'd1);
    edges = 0;
    while (!done && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check("latency", edges, (b == 32'h0) ? 32'd0 : 32'd32);
    check("quotient", quotient, exp[63:32]);
    check("remainder", remainder, exp[31:0]);
    check("div_by_zero", {31'b0, div_by_zero}, (b == 32'h0) ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    check("done_drop", {31'b0, done}, 32'd0);
    check("busy_drop", {31'b0, busy}, 32'd0);
    check("quotient_hold", quotient, exp[63:32]);
  endtask

  initial begin
    int          ndone;
    logic [31:0] a, b;
    logic [31:0] got_q, got_r;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_div(32'd100, 32'd7);
    run_div(32'hFFFF_FFFF, 32'd1);
    run_div(32'h1234_5678, 32'h1234_5679);
    run_div(32'd5, 32'd0);
    run_div(32'd17, 32'd4);

    // Start requests while running must be dropped.
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    ndone = 0;
    got_q = '0;
    got_r = '0;
    for (int i = 0; i < 40; i++) begin
      start    = (i < 31);
      dividend = $urandom;
      divisor  = $urandom_range(1, 50);
      if (done) begin
        ndone++;
        got_q = quotient;
        got_r = remainder;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("ignored_start_done_count", ndone, 32'd1);
    check("ignored_start_quotient", got_q, 32'd14);
    check("ignored_start_remainder", got_r, 32'd2);

    // Reset in the middle of an operation.
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_quotient", quotient, 32'd0);
    check("midrst_remainder", remainder, 32'd0);
    check("midrst_dbz", {31'b0, div_by_zero}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    check("midrst_no_done", ndone, 32'd0);
    run_div(32'd9, 32'd3);

`ifdef DIV_SIGNED_EN
    run_div(32'hFFFF_FFF9, 32'd2);
    run_div(32'd7, 32'hFFFF_FFFE);
    run_div(32'h8000_0000, 32'hFFFF_FFFF);
    run_div(32'hFFFF_FFF9, 32'hFFFF_FFFE);
    run_div(32'hFFFF_FFF9, 32'd0);
`endif

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom;
      run_div(a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/div_32.md
# div_32

Sequential restoring divider for the 32-bit ALU: the inverse of the adder/subtractor datapath. It accepts a dividend/divisor pair with a start pulse and produces quotient and remainder one bit per cycle. Each trial subtraction goes through an `add_sub_32` instance (parameter N+1) with sel=1. It sits beside the adder in the ALU and is used by the divide/modulo opcodes through a start/done handshake.

## Interface
- N, 32, operand width in bits; quotient and remainder are N bits.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  N  numerator; captured on accepted start.
- divisor  input  N  denominator; captured on accepted start.
- busy  output  1  high from accepted start through the DONE cycle.
- done  output  1  one-cycle pulse; results valid.
- quotient  output  N  registered result; held until the next done.
- remainder  output  N  registered result; held until the next done.
- div_by_zero  output  1  registered flag; updated together with done.

## Operation
- States:
  - IDLE→RUN on start=1 with divisor≠0.
  - IDLE→DONE on start=1 with divisor==0.
  - RUN→DONE after N iterations.
  - DONE→IDLE unconditionally.
- On accept: load Q←dividend, D←divisor, R←0 (N+1 bits), count←0.
- Each RUN cycle:
  - R'={R[N-1:0],Q[N-1]}; diff=R'−{0,D} via the N+1-bit add_sub (sel=1).
  - cout=1 (no borrow): R←diff, Q←{Q[N-2:0],1}.
  - cout=0: R←R', Q←{Q[N-2:0],0}.
- Final iteration, in the same edge: quotient←Q, remainder←R[N-1:0], div_by_zero←0.
- Divisor==0: quotient←all ones, remainder←dividend, div_by_zero←1. No iterations run.
- Arithmetic is unsigned unless the Configuration section enables signed mode. No other exceptions exist.
- start is ignored in RUN and DONE. No queuing: a request while busy is dropped.
- Result outputs never change except at the edge that raises done.

## Timing
- Reset:
  - State IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - The internal Q/R/D/count registers are cleared.
- Reset mid-operation: abort at that edge, all outputs return to reset values, and no done is issued.
- Let E0 be the edge that samples an accepted start:
  - Normal case: busy=1 after E0. Iterations occur on E1..EN. done=1 after EN for one cycle.
  - Normal case, closing edge: at EN+1, done=0, busy=0, state IDLE. Latency is N edges from E0 to done (32 for default N).
  - Divide by zero: done=1 and busy=1 after E0. At E1 both drop.
- Back-to-back: a new start is accepted at the first edge with state IDLE, i.e. EN+2 at the earliest (E2 for divide by zero).
- Operand inputs are don't-care except at E0.

## Configuration
- DIV_SIGNED_EN defined: operands are two's complement.
  - Magnitudes are divided. The quotient is negated when the operand signs differ, giving truncation toward zero.
  - The remainder takes the sign of the dividend.
  - −2^(N−1)/−1 yields quotient −2^(N−1), remainder 0, div_by_zero=0.
  - Divisor==0 gives quotient all ones, remainder=dividend.
  - Sign fix-up happens in the same edge that writes the results, so latency is unchanged.
- DIV_SIGNED_EN undefined: purely unsigned, with no sign logic present.

## Test plan
- 100/7, start at E0 → done=1 only after E32; quotient=14, remainder=2, div_by_zero=0, busy low after E33.
- 0xFFFFFFFF/1 then 0x12345678/0x12345679 back to back → (0xFFFFFFFF, 0) then (0, 0x12345678); second start accepted at the earliest allowed edge.
- 5/0 → done after E0; quotient=0xFFFFFFFF, remainder=5, div_by_zero=1; busy low after E1.
- Start pulses during RUN with different operands → ignored; the first result (100/7 → 14, 2) is unaffected and exactly one done is seen.
- rst_n=0 for one edge at iteration 10 → no done, all outputs 0. A new 9/3 request then yields quotient=3, remainder=0.
- DIV_SIGNED_EN:
  - −7/2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
  - 7/−2 → quotient=0xFFFFFFFD, remainder=1.
  - 0x80000000/0xFFFFFFFF → quotient=0x80000000, remainder=0.
